// File: rtl/fp_max.sv
// One-stage registered maximum of two IEEE-754 binary32 operands with index tags.
// The selected operand is copied bit-exact; NaNs lose to numbers, ties keep input1.
module fp_max #(
    parameter int DATAWIDTH  = 32,
    parameter int INDEXWIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATAWIDTH-1:0]  input1,
    input  logic [INDEXWIDTH-1:0] index1,
    input  logic [DATAWIDTH-1:0]  input2,
    input  logic [INDEXWIDTH-1:0] index2,
    output logic [DATAWIDTH-1:0]  maximum,
    output logic [INDEXWIDTH-1:0] indexmaximum,
    output logic                  out_valid
);

    logic                  sign1, sign2;
    logic [30:0]           mag1, mag2;
    logic                  nan1, nan2;
    logic                  both_zero;
    logic                  sel2;

    logic [DATAWIDTH-1:0]  max_d, max_q;
    logic [INDEXWIDTH-1:0] idx_d, idx_q;
    logic                  valid_d, valid_q;

    assign sign1 = input1[31];
    assign sign2 = input2[31];
    assign mag1  = input1[30:0];
    assign mag2  = input2[30:0];
    assign nan1  = (&input1[30:23]) && (|input1[22:0]);
    assign nan2  = (&input2[30:23]) && (|input2[22:0]);
    assign both_zero = (mag1 == 31'd0) && (mag2 == 31'd0);

    // sel2 is set only when input2 is strictly greater; every tie falls to input1.
    always_comb begin
        sel2 = 1'b0;
        if (nan1 && nan2) begin
            sel2 = 1'b0;
        end else if (nan1) begin
            sel2 = 1'b1;
        end else if (nan2) begin
            sel2 = 1'b0;
        end else if (both_zero) begin
            sel2 = 1'b0;
        end else if (sign1 != sign2) begin
            sel2 = sign1;
        end else if (!sign1) begin
            sel2 = (mag2 > mag1);
        end else begin
            sel2 = (mag2 < mag1);
        end
    end

    always_comb begin
        max_d   = max_q;
        idx_d   = idx_q;
        valid_d = in_valid;
        if (in_valid) begin
            max_d = sel2 ? input2 : input1;
            idx_d = sel2 ? index2 : index1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            max_q   <= max_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign maximum      = max_q;
    assign indexmaximum = idx_q;
    assign out_valid    = valid_q;

endmodule

// File: tb/tb_fp_max.sv
// Bench for fp_max: directed literal cases, streaming/reset, and random operands
// checked every cycle against an ordering-key model of IEEE-754 maximum.
module tb_fp_max;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] input1, input2;
    logic [3:0]  index1, index2;
    logic [31:0] maximum;
    logic [3:0]  indexmaximum;
    logic        out_valid;

    int checks   = 0;
    int failures = 0;

    fp_max #(.DATAWIDTH(32), .INDEXWIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .input1       (input1),
        .index1       (index1),
        .input2       (input2),
        .index2       (index2),
        .maximum      (maximum),
        .indexmaximum (indexmaximum),
        .out_valid    (out_valid)
    );

    always #5 clk = ~clk;

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Signed ordering key: value order of non-NaN floats, with +0 and -0 both 0.
    function automatic longint fkey(input logic [31:0] x);
        longint m;
        m = longint'(x[30:0]);
        return x[31] ? -m : m;
    endfunction

    function automatic bit pick_second(input logic [31:0] a, input logic [31:0] b);
        if (is_nan(a) && is_nan(b)) return 1'b0;
        if (is_nan(a)) return 1'b1;
        if (is_nan(b)) return 1'b0;
        return fkey(b) > fkey(a);
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    // Model state, updated from the inputs seen at each rising edge.
    logic [31:0] m_max = '0;
    logic [3:0]  m_idx = '0;
    logic        m_vld = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_max = '0; m_idx = '0; m_vld = 1'b0;
        end else begin
            m_vld = in_valid;
            if (in_valid) begin
                m_max = pick_second(input1, input2) ? input2 : input1;
                m_idx = pick_second(input1, input2) ? index2 : index1;
            end
        end
        #1;
        check32("model_maximum", maximum, m_max);
        check32("model_index", {28'd0, indexmaximum}, {28'd0, m_idx});
        check32("model_valid", {31'd0, out_valid}, {31'd0, m_vld});
    end

    task automatic drive(input logic [31:0] a, input logic [3:0] ia,
                         input logic [31:0] b, input logic [3:0] ib);
        @(negedge clk);
        in_valid = 1'b1;
        input1 = a; index1 = ia;
        input2 = b; index2 = ib;
    endtask

    task automatic directed(input string name, input logic [31:0] a, input logic [3:0] ia,
                            input logic [31:0] b, input logic [3:0] ib,
                            input logic [31:0] em, input logic [3:0] ei);
        drive(a, ia, b, ib);
        @(posedge clk);
        #2;
        check32({name, "_max"}, maximum, em);
        check32({name, "_idx"}, {28'd0, indexmaximum}, {28'd0, ei});
        check32({name, "_vld"}, {31'd0, out_valid}, 32'd1);
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: return {r[31], 31'd0};
            1: return {r[31], 8'hFF, 23'd0};
            2: return {r[31], 8'hFF, r[22:1], 1'b1};
            3: return {r[31], 8'h00, r[22:0]};
            4: return {r[31], 8'h3F, r[22:0]};
            default: return r;
        endcase
    endfunction

    initial begin
        logic [31:0] a, b;
        logic [31:0] last_max;
        logic [3:0]  last_idx;
        rst = 1'b1; in_valid = 1'b0;
        input1 = '0; input2 = '0; index1 = '0; index2 = '0;
        #2;
        check32("reset_max", maximum, 32'd0);
        check32("reset_vld", {31'd0, out_valid}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        directed("diff_exp",  32'h70691111, 4'd7, 32'h09f81142, 4'd3, 32'h70691111, 4'd7);
        directed("same_exp",  32'h10691111, 4'd2, 32'h10698142, 4'd8, 32'h10698142, 4'd8);
        directed("pos_pair",  32'h4cef1f13, 4'd4, 32'h6166fb42, 4'd9, 32'h6166fb42, 4'd9);
        directed("neg_pair",  32'hC0000000, 4'd1, 32'hBF800000, 4'd2, 32'hBF800000, 4'd2);
        directed("mixed_den", 32'h80000001, 4'd3, 32'h00000001, 4'd4, 32'h00000001, 4'd4);
        directed("zero_tie",  32'h80000000, 4'd5, 32'h00000000, 4'd6, 32'h80000000, 4'd5);
        directed("eq_tie",    32'h3F800000, 4'hA, 32'h3F800000, 4'hB, 32'h3F800000, 4'hA);
        directed("nan_one",   32'h7FC00000, 4'd1, 32'h3F800000, 4'd2, 32'h3F800000, 4'd2);
        directed("nan_both",  32'h7FC00000, 4'd1, 32'h7F800001, 4'd2, 32'h7FC00000, 4'd1);
        directed("ninf",      32'hFF800000, 4'd3, 32'hFF7FFFFF, 4'd5, 32'hFF7FFFFF, 4'd5);
        directed("pinf",      32'h7F7FFFFF, 4'd6, 32'h7F800000, 4'd9, 32'h7F800000, 4'd9);

        // Four back-to-back pairs, then idle: outputs must hold the fourth result.
        directed("strm0", 32'h3F800000, 4'd1, 32'h40000000, 4'd2, 32'h40000000, 4'd2);
        directed("strm1", 32'hC1000000, 4'd3, 32'h00000000, 4'd4, 32'h00000000, 4'd4);
        directed("strm2", 32'h7F800000, 4'd5, 32'h7F7FFFFF, 4'd6, 32'h7F800000, 4'd5);
        directed("strm3", 32'h80000002, 4'd7, 32'h80000001, 4'd8, 32'h80000001, 4'd8);
        @(negedge clk);
        in_valid = 1'b0;
        input1 = 32'h7F000000; input2 = 32'h7F000001;
        repeat (3) @(posedge clk);
        #2;
        check32("hold_max", maximum, 32'h80000001);
        check32("hold_idx", {28'd0, indexmaximum}, 32'd8);
        check32("hold_vld", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset between edges.
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check32("arst_max", maximum, 32'd0);
        check32("arst_idx", {28'd0, indexmaximum}, 32'd0);
        check32("arst_vld", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Random operand pairs with occasional equal, sign-flipped and idle cycles.
        for (int i = 0; i < 2000; i++) begin
            a = rand_op();
            case ($urandom_range(0, 5))
                0: b = a;
                1: b = {~a[31], a[30:0]};
                2: b = {a[31:23], 23'($urandom)};
                default: b = rand_op();
            endcase
            @(negedge clk);
            in_valid = ($urandom_range(0, 7) != 0);
            input1 = a; index1 = 4'($urandom);
            input2 = b; index2 = 4'($urandom);
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            else rst = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
